// File: rtl/gf_pkg.sv
// gf_pkg: GF(2^8) field constants and reduction-matrix builder shared by RTL and bench
package gf_pkg;
  localparam int GF_W = 8;
  localparam int Q_W = 56;
  localparam logic [GF_W-1:0] DEFAULT_POLY = 8'h1D;
  function automatic logic [Q_W-1:0] q_from_poly(input logic [GF_W-1:0] poly);
    logic [GF_W-1:0] r;
    q_from_poly = '0;
    r = poly;
    for (int s = 0; s < 7; s++) begin
      for (int j = 0; j < GF_W; j++) q_from_poly[7*j+s] = r[j];
      r = {r[6:0], 1'b0} ^ (r[7] ? poly : 8'h00);
    end
  endfunction
endpackage

// File: rtl/finite_field_multiplier_mastravito.sv
// finite_field_multiplier_mastravito: combinational GF(2^8) a*b reduced by matrix q (ports: a, b, q in; c out)
module finite_field_multiplier_mastravito
  import gf_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  input  logic [Q_W-1:0]  q,
  output logic [GF_W-1:0] c
);
  logic [2*GF_W-2:0] d;
  always_comb begin
    d = '0;
    for (int i = 0; i < GF_W; i++)
      for (int j = 0; j < GF_W; j++) d[i+j] = d[i+j] ^ (a[i] & b[j]);
    c = d[GF_W-1:0];
    for (int j = 0; j < GF_W; j++)
      for (int s = 0; s < 7; s++) c[j] = c[j] ^ (q[7*j+s] & d[GF_W+s]);
  end
endmodule

// File: rtl/gf_mul_arbiter_rr.sv
// gf_rr_arbiter: round-robin pick starting after the last winner (ports: clk, rst, en, valid in; grant, win out)
module gf_rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    valid,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] win
);
  logic [ID_W-1:0] ptr;
  logic found;
  int k;
  always_comb begin
    grant = '0;
    win = ptr;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (en && valid[k] && !found) begin
        found = 1'b1;
        grant[k] = 1'b1;
        win = ID_W'(k);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= ID_W'(N - 1);
    else if (found) ptr <= win;
endmodule

// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter: shared GF(2^8) multiplier with round-robin valid/ready requesters, registered tagged response and poly config sequencer (ports: clk, rst, poly_wr, poly, cfg_busy, req_valid/a/b/ready, rsp_valid/id/c/ready)
module gf_mul_arbiter
  import gf_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ),
  parameter logic [GF_W-1:0] RST_POLY = DEFAULT_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  poly_wr,
  input  logic [GF_W-1:0]       poly,
  output logic                  cfg_busy,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [GF_W*N_REQ-1:0] req_a,
  input  logic [GF_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [GF_W-1:0]       rsp_c,
  input  logic                  rsp_ready
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] CFG = 1'b1;
  logic [0:0] state;
  logic [2:0] s;
  logic [GF_W-1:0] r, poly_q, a_sel, b_sel, c;
  logic [Q_W-1:0] q;
  logic [ID_W-1:0] win;
  assign cfg_busy = state == CFG;
  assign a_sel = req_a[GF_W*win +: GF_W];
  assign b_sel = req_b[GF_W*win +: GF_W];
  gf_rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(state == RUN && (!rsp_valid || rsp_ready)),
    .valid(req_valid),
    .grant(req_ready),
    .win(win)
  );
  finite_field_multiplier_mastravito u_mul (.a(a_sel), .b(b_sel), .q(q), .c(c));
  // r walks x^(8+s) mod p; each CFG cycle writes it as column s of q
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      s <= '0;
      r <= RST_POLY;
      poly_q <= RST_POLY;
      q <= q_from_poly(RST_POLY);
    end else if (poly_wr) begin
      state <= CFG;
      s <= '0;
      r <= poly;
      poly_q <= poly;
    end else if (state == CFG) begin
      for (int j = 0; j < GF_W; j++) q[7*j+int'(s)] <= r[j];
      r <= {r[6:0], 1'b0} ^ (r[7] ? poly_q : 8'h00);
      s <= s + 3'd1;
      state <= s == 3'd6 ? RUN : CFG;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_c <= '0;
    end else if (|req_ready) begin
      rsp_valid <= 1'b1;
      rsp_id <= win;
      rsp_c <= c;
    end else if (rsp_ready) rsp_valid <= 1'b0;
endmodule

// File: tb/tb_gf_mul_arbiter.sv
// tb_gf_mul_arbiter: self-checking bench for gf_mul_arbiter against a shift-and-add GF model
module tb_gf_mul_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, poly_wr, cfg_busy, rsp_valid, rsp_ready;
  logic [7:0] poly, rsp_c;
  logic [N-1:0] req_valid, req_ready;
  logic [8*N-1:0] req_a, req_b;
  logic [1:0] rsp_id;
  int checks = 0, errors = 0;
  int ptr;
  logic [7:0] cur_poly;
  always #5 clk = ~clk;
  gf_mul_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .poly_wr(poly_wr), .poly(poly), .cfg_busy(cfg_busy),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_ready(rsp_ready)
  );
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
    logic [7:0] acc, x;
    acc = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? p : 8'h00);
    end
    return acc;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic busy_len(output int n, output bit leak);
    n = 0;
    leak = 0;
    req_valid = '1;
    while (cfg_busy && n < 20) begin
      n++;
      if (req_ready !== '0) leak = 1;
      tick();
    end
    req_valid = '0;
  endtask
  task automatic test_reset;
    rst = 1; poly_wr = 0; poly = 0; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 1;
    #22;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy got %b want 0", cfg_busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_c !== 8'h00) begin errors++; $display("FAIL reset_rsp_c got %h want 00", rsp_c); end
    @(negedge clk);
    rst = 0; cur_poly = 8'h1D; ptr = N - 1;
    tick();
  endtask
  task automatic test_basic;
    req_valid = 4'b0001; req_a[7:0] = 8'h02; req_b[7:0] = 8'h80;
    #3;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got %b want 0001", req_ready); end
    tick();
    req_valid = 0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_c !== 8'h1D) begin errors++; $display("FAIL basic_rsp_c got %h want 1d", rsp_c); end
    ptr = 0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_clear got %b want 0", rsp_valid); end
  endtask
  task automatic test_poly;
    int n;
    bit leak;
    poly_wr = 1; poly = 8'h1B;
    tick();
    poly_wr = 0; cur_poly = 8'h1B;
    busy_len(n, leak);
    checks++; if (n != 7) begin errors++; $display("FAIL poly_busy_len got %0d want 7", n); end
    checks++; if (leak) begin errors++; $display("FAIL poly_ready_in_cfg got 1 want 0"); end
    req_valid = 4'b0100; req_a[23:16] = 8'h53; req_b[23:16] = 8'hCA;
    #3;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL poly_grant got %b want 0100", req_ready); end
    tick();
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL poly_id got %0d want 2", rsp_id); end
    checks++; if (rsp_c !== 8'h01) begin errors++; $display("FAIL poly_c1 got %h want 01", rsp_c); end
    ptr = 2;
    req_a[23:16] = 8'h57; req_b[23:16] = 8'h83;
    tick();
    req_valid = 0;
    checks++; if (rsp_c !== 8'hC1) begin errors++; $display("FAIL poly_c2 got %h want c1", rsp_c); end
    tick();
  endtask
  task automatic test_round_robin;
    int e;
    logic [7:0] ea, eb;
    for (int k = 0; k < N; k++) begin req_a[8*k +: 8] = 8'($urandom); req_b[8*k +: 8] = 8'($urandom); end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      e = (ptr + 1) % N;
      ea = req_a[8*e +: 8]; eb = req_b[8*e +: 8];
      #3;
      checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_grant got %b want %b", req_ready, 4'(1 << e)); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== e[1:0]) begin errors++; $display("FAIL rr_id got %b/%0d want 1/%0d", rsp_valid, rsp_id, e); end
      checks++; if (rsp_c !== gmul(ea, eb, cur_poly)) begin errors++; $display("FAIL rr_c got %h want %h", rsp_c, gmul(ea, eb, cur_poly)); end
      ptr = e;
      req_a[8*e +: 8] = 8'($urandom); req_b[8*e +: 8] = 8'($urandom);
    end
  endtask
  task automatic test_backpressure;
    logic [1:0] hid;
    logic [7:0] hc;
    int e;
    rsp_ready = 0; hid = rsp_id; hc = rsp_c;
    repeat (5) begin
      #3;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_c !== hc) begin errors++; $display("FAIL bp_hold got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_c, hid, hc); end
      tick();
    end
    rsp_ready = 1;
    e = (ptr + 1) % N;
    #3;
    checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL bp_release_grant got %b want %b", req_ready, 4'(1 << e)); end
    tick();
    checks++; if (rsp_id !== e[1:0] || rsp_c !== gmul(req_a[8*e +: 8], req_b[8*e +: 8], cur_poly)) begin errors++; $display("FAIL bp_release_rsp got %0d/%h want %0d/%h", rsp_id, rsp_c, e, gmul(req_a[8*e +: 8], req_b[8*e +: 8], cur_poly)); end
    ptr = e;
    req_valid = 0;
    tick();
  endtask
  task automatic test_restart;
    int n;
    bit leak;
    logic [7:0] a, b;
    poly_wr = 1; poly = 8'h4D;
    tick();
    poly_wr = 0;
    repeat (3) tick();
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL restart_mid_cfg got %b want 1", cfg_busy); end
    poly_wr = 1; poly = 8'h65;
    tick();
    poly_wr = 0; cur_poly = 8'h65;
    busy_len(n, leak);
    checks++; if (n != 7 || leak) begin errors++; $display("FAIL restart_busy_len got %0d/%b want 7/0", n, leak); end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      req_valid = 4'b0010; req_a[15:8] = a; req_b[15:8] = b;
      #3;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL restart_grant got %b want 0010", req_ready); end
      tick();
      checks++; if (rsp_id !== 2'd1 || rsp_c !== gmul(a, b, 8'h65)) begin errors++; $display("FAIL restart_c got %0d/%h want 1/%h", rsp_id, rsp_c, gmul(a, b, 8'h65)); end
      ptr = 1;
    end
    req_valid = 0;
    tick();
  endtask
  task automatic test_rst_mid;
    poly_wr = 1; poly = 8'h1B;
    tick();
    poly_wr = 0;
    tick();
    #2 rst = 1;
    #1;
    checks++; if (cfg_busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rst_cfg got %b/%b/%b want 0/0/0000", cfg_busy, rsp_valid, req_ready); end
    @(negedge clk);
    rst = 0; cur_poly = 8'h1D; ptr = N - 1;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      req_valid = 4'b0001; req_a[7:0] = 8'h02; req_b[7:0] = 8'h80; rsp_ready = 1;
      #3;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_grant got %b want 0001", req_ready); end
      tick();
      checks++; if (rsp_id !== 2'd0 || rsp_c !== 8'h1D) begin errors++; $display("FAIL rst_c got %0d/%h want 0/1d", rsp_id, rsp_c); end
      ptr = 0;
      if (pass == 0) begin
        req_valid = '1;
        tick();
        rsp_ready = 0; req_valid = 0;
        #2 rst = 1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_c !== 8'h00 || req_ready !== 4'b0) begin errors++; $display("FAIL rst_stream got %b/%0d/%h/%b want 0/0/00/0000", rsp_valid, rsp_id, rsp_c, req_ready); end
        @(negedge clk);
        rst = 0; ptr = N - 1;
        tick();
      end
    end
    req_valid = 0;
    tick();
  endtask
  task automatic test_random;
    bit pend [N];
    logic [7:0] pa [N], pb [N];
    bit m_valid;
    logic [1:0] m_id;
    logic [7:0] m_c;
    int g, k;
    for (int i = 0; i < N; i++) pend[i] = 0;
    m_valid = 0; m_id = 0; m_c = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin pend[i] = 1; pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        req_valid[i] = pend[i]; req_a[8*i +: 8] = pa[i]; req_b[8*i +: 8] = pb[i];
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      g = -1;
      if (!m_valid || rsp_ready)
        for (int i = 1; i <= N && g < 0; i++) begin k = (ptr + i) % N; if (pend[k]) g = k; end
      #3;
      checks++; if (req_ready !== (g >= 0 ? 4'(1 << g) : 4'b0)) begin errors++; $display("FAIL rand_grant cyc %0d got %b want %b", cyc, req_ready, g >= 0 ? 4'(1 << g) : 4'b0); end
      tick();
      if (g >= 0) begin
        m_valid = 1; m_id = g[1:0]; m_c = gmul(pa[g], pb[g], cur_poly); pend[g] = 0; ptr = g;
      end else if (rsp_ready) m_valid = 0;
      checks++; if (rsp_valid !== m_valid || (m_valid && (rsp_id !== m_id || rsp_c !== m_c))) begin errors++; $display("FAIL rand_rsp cyc %0d got %b/%0d/%h want %b/%0d/%h", cyc, rsp_valid, rsp_id, rsp_c, m_valid, m_id, m_c); end
    end
    req_valid = 0; rsp_ready = 1;
    tick();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_poly();
    test_round_robin();
    test_backpressure();
    test_restart();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
